// File: rtl/dma_pkg.sv
// Shared DMA link definitions for the responder and the initiator (dmaController).
package dma_pkg;
  localparam int unsigned DMA_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CLOSE  = 2'd2
  } dma_resp_state_t;
endpackage

// File: rtl/dma_responder_if.sv
// DMA session plus write/read valid-ready channels between initiator (master) and responder (slave).
interface dma_responder_if
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_DATA_W
);
  logic              dma_req;
  logic              dma_resp;
  logic              dma_write_valid;
  logic [DATA_W-1:0] dma_write_data;
  logic              dma_write_ready;
  logic              dma_read_valid;
  logic [DATA_W-1:0] dma_read_data;
  logic              dma_read_ready;

  modport master (
    output dma_req, dma_write_valid, dma_write_data, dma_read_ready,
    input  dma_resp, dma_write_ready, dma_read_valid, dma_read_data
  );

  modport slave (
    input  dma_req, dma_write_valid, dma_write_data, dma_read_ready,
    output dma_resp, dma_write_ready, dma_read_valid, dma_read_data
  );
endinterface

// File: rtl/dma_resp_fifo.sv
// First-word-fall-through FIFO with separate occupancy count; head holds its last value when empty.
module dma_resp_fifo #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    pop,
  input  logic                    flush,
  output logic [DATA_W-1:0]       head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [DATA_W-1:0] last_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_q;
  assign head    = empty ? last_q : mem[rd_ptr_q];

  // Storage is not reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Tracks the presented head so read data holds steady once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_q <= '0;
    else if (!empty) last_q <= mem[rd_ptr_q];
  end
endmodule

// File: rtl/dma_responder.sv
// DMA target: grants sessions, buffers write beats and loops them back on the read channel.
module dma_responder
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W         = DMA_DATA_W,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned COUNT_W        = 16,
  parameter bit          FLUSH_ON_CLOSE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  dma_responder_if.slave         bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [COUNT_W-1:0]     wr_beats,
  output logic [COUNT_W-1:0]     rd_beats,
  output logic                   session_done
);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  dma_resp_state_t state_q, state_d;
  logic            resp_q;
  logic            done_q;
  logic            active;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;

  // Session state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= (state_d == ACTIVE);
      done_q  <= (state_d == CLOSE);
    end
  end

  // Session next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.dma_req)  state_d = ACTIVE;
      ACTIVE:  if (!bus.dma_req) state_d = CLOSE;
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign active              = (state_q == ACTIVE);
  assign bus.dma_resp        = resp_q;
  assign session_done        = done_q;
  assign bus.dma_write_ready = active && !full;
  assign bus.dma_read_valid  = active && !empty;
  assign push                = bus.dma_write_valid && bus.dma_write_ready;
  assign pop                 = bus.dma_read_valid && bus.dma_read_ready;
  assign flush               = FLUSH_ON_CLOSE && (state_q == CLOSE);

  dma_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.dma_write_data),
    .pop   (pop),
    .flush (flush),
    .head  (bus.dma_read_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Per-session saturating beat counters; cleared on grant, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_beats <= '0;
      rd_beats <= '0;
    end else if (state_q == IDLE && state_d == ACTIVE) begin
      wr_beats <= '0;
      rd_beats <= '0;
    end else begin
      if (push && wr_beats != CNT_MAX) wr_beats <= wr_beats + COUNT_W'(1);
      if (pop && rd_beats != CNT_MAX)  rd_beats <= rd_beats + COUNT_W'(1);
    end
  end
endmodule
